// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux: AHB-Lite data-phase response mux for four slave ports.
// Define AHBLITE_MUX_DEFAULT_SLAVE_EN to build the two-cycle ERROR default slave.
module ahblite_slave_mux #(
    parameter bit Port0_en = 1'b1,
    parameter bit Port1_en = 1'b1,
    parameter bit Port2_en = 1'b1,
    parameter bit Port3_en = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    logic [3:0] port_en;
    logic [3:0] sel_raw;
    logic [3:0] sel_masked;
    logic [3:0] sel_eff;
    logic [3:0] sel_q;
    logic       dflt_active;
    logic       dflt_ready;
    logic       dflt_resp;

    assign port_en    = {Port3_en, Port2_en, Port1_en, Port0_en};
    assign sel_raw    = {P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
    assign sel_masked = sel_raw & port_en;

    // Isolate the lowest set bit so the lowest-index enabled port wins
    assign sel_eff = sel_masked & (~sel_masked + 4'd1);

    // Capture the data-phase owner whenever an address phase is accepted
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= 4'b0000;
        end else if (HREADY) begin
            sel_q <= sel_eff;
        end
    end

`ifdef AHBLITE_MUX_DEFAULT_SLAVE_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       unmapped;

    assign unmapped = HREADY & HTRANS[1] & ~(|sel_eff);

    // Default slave sequencing for the two-cycle ERROR response
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (unmapped) state_nxt = ST_ERR1;
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = unmapped ? ST_ERR1 : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Default slave state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign dflt_active = (state != ST_IDLE);
    assign dflt_ready  = (state != ST_ERR1);
    assign dflt_resp   = 1'b1;
`else
    assign dflt_active = 1'b0;
    assign dflt_ready  = 1'b1;
    assign dflt_resp   = 1'b0;
`endif

    // Route the data-phase owner's response; idle gives zero-wait OKAY
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        if (dflt_active) begin
            HREADYOUT = dflt_ready;
            HRESP     = dflt_resp;
        end else begin
            unique case (1'b1)
                sel_q[0]: begin
                    HREADYOUT = P0_HREADYOUT;
                    HRESP     = P0_HRESP;
                    HRDATA    = P0_HRDATA;
                end
                sel_q[1]: begin
                    HREADYOUT = P1_HREADYOUT;
                    HRESP     = P1_HRESP;
                    HRDATA    = P1_HRDATA;
                end
                sel_q[2]: begin
                    HREADYOUT = P2_HREADYOUT;
                    HRESP     = P2_HRESP;
                    HRDATA    = P2_HRDATA;
                end
                sel_q[3]: begin
                    HREADYOUT = P3_HREADYOUT;
                    HRESP     = P3_HRESP;
                    HRDATA    = P3_HRDATA;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ahblite_slave_mux.md
AHBLITE_SLAVE_MUX -- requirements
Module: ahblite_slave_mux

Interface
REQ-001 Port0_en, default 1, SHALL enable slave port 0 (RAMCODE); 0 = port treated as unmapped.
REQ-002 Port1_en, default 1, SHALL enable slave port 1 (RAMDATA); 0 = unmapped.
REQ-003 Port2_en, default 1, SHALL enable slave port 2 (APB bridge); 0 = unmapped.
REQ-004 Port3_en, default 1, SHALL enable slave port 3 (ACC); 0 = unmapped.
REQ-005 HCLK  input  1  bus clock; all state on rising edge; the only clock.
REQ-006 HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-007 HREADY  input  1  bus-level HREADY (this block's HREADYOUT fed back); marks address-phase acceptance.
REQ-008 HTRANS  input  2  current transfer type; bit 1 = NONSEQ/SEQ.
REQ-009 P0_HSEL..P3_HSEL  input  1 each  one-hot select from the address decoder.
REQ-010 P0_HREADYOUT..P3_HREADYOUT  input  1 each  slave ready.
REQ-011 P0_HRESP..P3_HRESP  input  1 each  slave response (1 = ERROR).
REQ-012 P0_HRDATA..P3_HRDATA  input  32 each  slave read data.
REQ-013 HREADYOUT  output  1  muxed ready to master.
REQ-014 HRESP  output  1  muxed response to master.
REQ-015 HRDATA  output  32  muxed read data to master.

Function
REQ-016 Effective select: Px_HSEL AND Portx_en; if several asserted, lowest index SHALL win.
REQ-017 On each HCLK edge with HREADY=1, the block SHALL register the effective one-hot select (sel_q) for the data phase; with HREADY=0, sel_q SHALL hold.
REQ-018 Unmapped transfer: HREADY=1, HTRANS[1]=1, no effective select; SHALL arm the default slave for the next cycle.
REQ-019 During data phase, HREADYOUT/HRESP/HRDATA SHALL combinationally follow the port named by sel_q (zero added latency).
REQ-020 No port selected and default slave idle: HREADYOUT=1, HRESP=0, HRDATA=32'h0.
REQ-021 Default slave FSM states IDLE, ERR1, ERR2: IDLE->ERR1 on REQ-018; ERR1->ERR2 unconditionally; ERR2->ERR1 if another unmapped transfer is accepted that cycle, else IDLE.
REQ-022 ERR1 SHALL drive HREADYOUT=0, HRESP=1; ERR2 SHALL drive HREADYOUT=1, HRESP=1 (AHB-Lite two-cycle ERROR); HRDATA=0 in both.
REQ-023 IDLE/BUSY transfers to unmapped space SHALL get zero-wait OKAY.
REQ-024 Mapped transfer accepted during ERR2 SHALL select that port for the following data phase and FSM returns IDLE.
REQ-025 Slave wait states (Px_HREADYOUT=0) SHALL propagate unchanged; sel_q held until HREADYOUT=1.

Reset
REQ-026 HRESETn low SHALL immediately clear sel_q to 0 and FSM to IDLE, giving HREADYOUT=1, HRESP=0, HRDATA=0, including mid-wait-state or mid-ERROR.
REQ-027 After release, first accepted address phase SHALL be handled normally; no spurious response.

Configuration
REQ-028 Macro AHBLITE_MUX_DEFAULT_SLAVE_EN defined: default slave FSM (REQ-021/022) built in.
REQ-029 Macro undefined: no FSM; unmapped transfers SHALL get zero-wait OKAY with HRDATA=0; all other behaviour identical.

Verification
REQ-030 Read 0x00000004, P0_HRDATA=32'hA5A5_0001, P0 one wait state -> HREADYOUT 0 then 1, HRDATA=32'hA5A5_0001, HRESP=0.
REQ-031 NONSEQ to 0x30000000 (no HSEL), macro defined -> next cycle HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then IDLE.
REQ-032 Same stimulus, macro undefined -> HREADYOUT=1, HRESP=0, HRDATA=0 in data phase.
REQ-033 Back-to-back unmapped NONSEQ then read of 0x20000000 (P1_HRDATA=32'h1234_5678) -> ERR1,ERR2,ERR1,ERR2 never; ERR1,ERR2 then P1 data 32'h1234_5678 OKAY.
REQ-034 Port2_en=0, access 0x40000000 -> treated as unmapped ERROR; P2_HRDATA never reaches HRDATA.
REQ-035 HRESETn low during ERR1 -> same cycle HREADYOUT=1, HRESP=0; after release, read 0x00000000 returns P0 data.
